// File: rtl/ysyx_25040129_regfile_sb.sv
// Parametrised integer register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle writeback bypass; x0 and out-of-range indices read as zero.
module ysyx_25040129_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 16,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      rs1_id,
   input  logic [4:0]      rs2_id,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            illegal_idx
);

   localparam int IW = $clog2(NREG);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;

   logic rs1_ok, rs2_ok, issue_ok, wb_ok;
   logic wb_en, issue_en;

   function automatic logic in_range(input logic [4:0] idx);
      return {27'b0, idx} < 32'(NREG);
   endfunction

   assign rs1_ok   = in_range(rs1_id);
   assign rs2_ok   = in_range(rs2_id);
   assign issue_ok = in_range(issue_rd);
   assign wb_ok    = in_range(wb_rd);

   // x0 and out-of-range destinations are never written nor marked busy
   assign wb_en    = wb_valid && wb_ok && (wb_rd != 5'd0);
   assign issue_en = issue_valid && issue_ok && (issue_rd != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en) begin
         regs[wb_rd[IW-1:0]] <= wb_data;
      end
   end

   // Flush clears every entry; otherwise issue takes precedence over a same-cycle writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (flush) begin
               busy[r] <= 1'b0;
            end else if (issue_en && (issue_rd == 5'(r))) begin
               busy[r] <= 1'b1;
            end else if (wb_en && (wb_rd == 5'(r))) begin
               busy[r] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      if (rst_n && rs1_ok && (rs1_id != 5'd0)) begin
         rs1_data = regs[rs1_id[IW-1:0]];
         rs1_busy = busy[rs1_id[IW-1:0]];
         if ((BYPASS != 0) && wb_valid && (wb_rd == rs1_id)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
         end
      end
   end

   always_comb begin
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (rst_n && rs2_ok && (rs2_id != 5'd0)) begin
         rs2_data = regs[rs2_id[IW-1:0]];
         rs2_busy = busy[rs2_id[IW-1:0]];
         if ((BYPASS != 0) && wb_valid && (wb_rd == rs2_id)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
         end
      end
   end

   assign illegal_idx = rst_n && (!rs1_ok || !rs2_ok ||
                                  (issue_valid && !issue_ok) ||
                                  (wb_valid && !wb_ok));

endmodule

// File: tb/tb_ysyx_25040129_regfile_sb.sv
// Bench for ysyx_25040129_regfile_sb: three configurations share one stimulus stream
// (NREG=16/BYPASS=1, NREG=16/BYPASS=0, NREG=32/BYPASS=1) and are checked against an array model.
module tb_ysyx_25040129_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_id, rs2_id, issue_rd, wb_rd;
   logic        issue_valid, wb_valid, flush;
   logic [31:0] wb_data;

   logic [31:0] r1d [3];
   logic [31:0] r2d [3];
   logic        r1b [3];
   logic        r2b [3];
   logic        ill [3];

   int vectors = 0;
   int miscompares = 0;

   int nreg_c [3] = '{16, 16, 32};
   int byp_c  [3] = '{1, 0, 1};

   logic [31:0] mregs [3][32];
   logic        mbusy [3][32];

   always #5 clk = ~clk;

   ysyx_25040129_regfile_sb #(.XLEN(32), .NREG(16), .BYPASS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_data(r1d[0]), .rs2_data(r2d[0]), .rs1_busy(r1b[0]), .rs2_busy(r2b[0]),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .illegal_idx(ill[0]));

   ysyx_25040129_regfile_sb #(.XLEN(32), .NREG(16), .BYPASS(0)) u1 (
      .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_data(r1d[1]), .rs2_data(r2d[1]), .rs1_busy(r1b[1]), .rs2_busy(r2b[1]),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .illegal_idx(ill[1]));

   ysyx_25040129_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_data(r1d[2]), .rs2_data(r2d[2]), .rs1_busy(r1b[2]), .rs2_busy(r2b[2]),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .illegal_idx(ill[2]));

   function automatic bit in_rng(int k, logic [4:0] id);
      return int'(id) < nreg_c[k];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++) begin
            mregs[k][i] = '0;
            mbusy[k][i] = 1'b0;
         end
   endtask

   // Applies one rising edge worth of architectural effects to the model
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         bit wb_ok, is_ok;
         wb_ok = wb_valid && wb_rd != 5'd0 && in_rng(k, wb_rd);
         is_ok = issue_valid && issue_rd != 5'd0 && in_rng(k, issue_rd);
         if (wb_ok) mregs[k][wb_rd] = wb_data;
         if (flush) begin
            for (int i = 0; i < 32; i++) mbusy[k][i] = 1'b0;
         end else begin
            if (wb_ok) mbusy[k][wb_rd] = 1'b0;
            if (is_ok) mbusy[k][issue_rd] = 1'b1;
         end
      end
   endtask

   task automatic exp_port(int k, logic [4:0] id, output logic [31:0] d, output logic b);
      d = '0;
      b = 1'b0;
      if (rst_n && id != 5'd0 && in_rng(k, id)) begin
         if (byp_c[k] != 0 && wb_valid && wb_rd == id) begin
            d = wb_data;
         end else begin
            d = mregs[k][id];
            b = mbusy[k][id];
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h (t=%0t rs1=%0d rs2=%0d)", tag, obs, exp, $time, rs1_id, rs2_id);
      end
   endtask

   task automatic check_all();
      logic [31:0] d1, d2;
      logic        b1, b2, e_ill;
      for (int k = 0; k < 3; k++) begin
         exp_port(k, rs1_id, d1, b1);
         exp_port(k, rs2_id, d2, b2);
         e_ill = rst_n && (!in_rng(k, rs1_id) || !in_rng(k, rs2_id) ||
                           (issue_valid && !in_rng(k, issue_rd)) ||
                           (wb_valid && !in_rng(k, wb_rd)));
         chk($sformatf("u%0d.rs1_data", k), r1d[k], d1);
         chk($sformatf("u%0d.rs2_data", k), r2d[k], d2);
         chk($sformatf("u%0d.rs1_busy", k), 32'(r1b[k]), 32'(b1));
         chk($sformatf("u%0d.rs2_busy", k), 32'(r2b[k]), 32'(b2));
         chk($sformatf("u%0d.illegal_idx", k), 32'(ill[k]), 32'(e_ill));
      end
   endtask

   // Called at posedge+1: check mid-cycle, take the edge, update the model
   task automatic step();
      #3;
      check_all();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      wb_valid    = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic wb(logic [4:0] rd, logic [31:0] d);
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
   endtask

   task automatic issue(logic [4:0] rd);
      issue_valid = 1'b1;
      issue_rd    = rd;
   endtask

   initial begin
      rst_n = 1'b0;
      rs1_id = '0; rs2_id = '0; issue_rd = '0; wb_rd = '0; wb_data = '0;
      idle();
      model_reset();
      @(posedge clk);
      #1;
      // reset state, with a write attempted during reset
      wb(5'd3, 32'hFFFF_FFFF);
      rs1_id = 5'd3;
      step();
      step();
      idle();
      rst_n = 1'b1;
      step();

      // fill registers, then async reset mid-cycle
      for (int i = 1; i < 32; i++) begin
         wb(5'(i), 32'hA5A5_0000 + 32'(i));
         issue(5'(32 - i));
         rs1_id = 5'(i - 1);
         rs2_id = 5'(i);
         step();
      end
      idle();
      rs1_id = 5'd15;
      rs2_id = 5'd31;
      step();
      #3;
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 32; i++) begin
         rs1_id = 5'(i);
         rs2_id = 5'(31 - i);
         #1;
         check_all();
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // write x5, read back; x0 writes dropped
      wb(5'd5, 32'hDEAD_BEEF);
      step();
      idle();
      rs1_id = 5'd5;
      step();
      wb(5'd0, 32'h0000_1234);
      step();
      idle();
      rs1_id = 5'd0;
      rs2_id = 5'd0;
      step();

      // bypass: x7 holds 0x11 and is busy, then writeback 0x42 observed same cycle
      wb(5'd7, 32'h0000_0011);
      issue(5'd7);
      step();
      idle();
      wb(5'd7, 32'h0000_0042);
      rs2_id = 5'd7;
      step();
      idle();
      step();

      // scoreboard: issue, later wb; then issue+wb same cycle
      issue(5'd3);
      step();
      idle();
      rs1_id = 5'd3;
      step();
      wb(5'd3, 32'h3333_0003);
      step();
      idle();
      step();
      issue(5'd3);
      wb(5'd3, 32'h3333_0004);
      step();
      idle();
      step();

      // flush with a concurrent writeback
      issue(5'd4); step();
      issue(5'd6); step();
      issue(5'd9); step();
      idle();
      rs1_id = 5'd6; rs2_id = 5'd9;
      step();
      flush = 1'b1;
      wb(5'd6, 32'h0000_0077);
      issue(5'd4);
      step();
      idle();
      step();
      rs1_id = 5'd4;
      step();

      // out-of-range indices
      rs1_id = 5'd20;
      step();
      rs1_id = 5'd1;
      wb(5'd17, 32'hBAD0_0017);
      step();
      idle();
      issue(5'd18);
      rs1_id = 5'd17;
      rs2_id = 5'd18;
      step();
      wb(5'd31, 32'h3131_3131);
      issue(5'd30);
      step();
      idle();
      rs1_id = 5'd31;
      rs2_id = 5'd30;
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rs1_id      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
         rs2_id      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
         issue_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
         wb_rd       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
         issue_valid = 1'($urandom_range(0, 1));
         wb_valid    = 1'($urandom_range(0, 1));
         flush       = ($urandom_range(0, 19) == 0);
         wb_data     = $urandom;
         step();
      end
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
